// File: rtl/pc_sequencer.sv
// pc_sequencer
// Fetch/decode/execute sequencer for a 4-bit loadable program counter.
// Every instruction takes three cycles: FETCH latches the instruction word,
// DECODE decides what the PC should do, and EXEC presents that decision on
// the PC control pins. The PC moves on the rising edge that ends EXEC.
// A small LIFO of return addresses supports CALL and RET.
//
// Ports:
//   clock       system clock, rising edge
//   reset       synchronous, active-low reset
//   pc_value    current PC count value
//   pc_tc       PC terminal count (PC == 15)
//   instr       instruction word at pc_value, [7:4] opcode, [3:0] operand
//   zero_flag   ALU zero flag, sampled during DECODE
//   pc_load_n   active-low parallel load to the PC
//   pc_hold     1 = PC holds, 0 = PC increments (when pc_load_n = 1)
//   pc_target   parallel load value for the PC
//   ir          latched instruction register
//   exec_strobe 1 during the EXEC cycle
//   halted      1 once HALT has executed
//   stack_err   sticky return-stack overflow/underflow flag
//   wrap_event  one-cycle pulse when an increment wraps 15 -> 0
module pc_sequencer #(
   parameter int STACK_DEPTH = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [3:0] pc_value,
   input  logic       pc_tc,
   input  logic [7:0] instr,
   input  logic       zero_flag,
   output logic       pc_load_n,
   output logic       pc_hold,
   output logic [3:0] pc_target,
   output logic [7:0] ir,
   output logic       exec_strobe,
   output logic       halted,
   output logic       stack_err,
   output logic       wrap_event
);

   // The stack pointer must be able to hold STACK_DEPTH itself (full),
   // while the storage index only needs to address the entries.
   localparam int SPW = $clog2(STACK_DEPTH + 1);
   localparam int IW  = $clog2(STACK_DEPTH);
   localparam logic [SPW-1:0] SP_ONE  = SPW'(1);
   localparam logic [SPW-1:0] SP_FULL = SPW'(STACK_DEPTH);

   localparam logic [3:0] OP_JMP  = 4'h1;
   localparam logic [3:0] OP_JZ   = 4'h2;
   localparam logic [3:0] OP_JNZ  = 4'h3;
   localparam logic [3:0] OP_CALL = 4'h4;
   localparam logic [3:0] OP_RET  = 4'h5;
   localparam logic [3:0] OP_HALT = 4'h6;

   typedef enum logic [1:0] {
      ST_FETCH  = 2'd0,
      ST_DECODE = 2'd1,
      ST_EXEC   = 2'd2,
      ST_HALTED = 2'd3
   } state_t;

   state_t         state_q, state_d;
   logic [7:0]     ir_q, ir_d;
   logic           pc_load_n_q, pc_load_n_d;
   logic           pc_hold_q, pc_hold_d;
   logic [3:0]     pc_target_q, pc_target_d;
   logic           exec_strobe_q, exec_strobe_d;
   logic           halted_q, halted_d;
   logic           stack_err_q, stack_err_d;
   logic           wrap_event_q, wrap_event_d;
   logic [SPW-1:0] sp_q, sp_d;

   logic [3:0]     stack_q [STACK_DEPTH];
   logic           push_en;
   logic [3:0]     push_data;
   logic [IW-1:0]  wr_idx;
   logic [IW-1:0]  rd_idx;

   logic           do_load;
   logic           do_inc;
   logic [3:0]     load_target;
   logic [3:0]     opcode;

   // A push writes the slot at the current pointer; a pop reads the slot
   // just below it. Both indices are only used when in range.
   assign wr_idx = sp_q[IW-1:0];
   assign rd_idx = IW'(sp_q - SP_ONE);
   assign opcode = ir_q[7:4];

   // Next-state and next-output logic. Outside EXEC the PC is frozen, so
   // the load/hold defaults are the idle values and only DECODE can arm
   // a load or increment for the following EXEC cycle.
   always_comb begin
      state_d       = state_q;
      ir_d          = ir_q;
      pc_load_n_d   = 1'b1;
      pc_hold_d     = 1'b1;
      pc_target_d   = pc_target_q;
      exec_strobe_d = 1'b0;
      halted_d      = halted_q;
      stack_err_d   = stack_err_q;
      wrap_event_d  = 1'b0;
      sp_d          = sp_q;
      push_en       = 1'b0;
      push_data     = 4'd0;
      do_load       = 1'b0;
      do_inc        = 1'b0;
      load_target   = ir_q[3:0];

      case (state_q)
         ST_FETCH: begin
            ir_d    = instr;
            state_d = ST_DECODE;
         end

         ST_DECODE: begin
            state_d = ST_EXEC;
            case (opcode)
               OP_JMP: do_load = 1'b1;
               OP_JZ: begin
                  do_load = zero_flag;
                  do_inc  = ~zero_flag;
               end
               OP_JNZ: begin
                  do_load = ~zero_flag;
                  do_inc  = zero_flag;
               end
               OP_CALL: begin
                  // The jump is taken even when the return address is lost.
                  do_load = 1'b1;
                  if (sp_q == SP_FULL) begin
                     stack_err_d = 1'b1;
                  end else begin
                     push_en   = 1'b1;
                     push_data = pc_value + 4'd1;
                     sp_d      = sp_q + SP_ONE;
                  end
               end
               OP_RET: begin
                  // Underflow falls through to the next instruction.
                  if (sp_q == '0) begin
                     stack_err_d = 1'b1;
                     do_inc      = 1'b1;
                  end else begin
                     do_load     = 1'b1;
                     load_target = stack_q[rd_idx];
                     sp_d        = sp_q - SP_ONE;
                  end
               end
               OP_HALT: begin
                  state_d  = ST_HALTED;
                  halted_d = 1'b1;
               end
               default: do_inc = 1'b1;
            endcase

            if (opcode != OP_HALT) begin
               exec_strobe_d = 1'b1;
               pc_load_n_d   = ~do_load;
               pc_hold_d     = ~do_inc;
               wrap_event_d  = do_inc & pc_tc;
               if (do_load) begin
                  pc_target_d = load_target;
               end
            end
         end

         ST_EXEC: state_d = ST_FETCH;

         ST_HALTED: halted_d = 1'b1;

         default: state_d = ST_FETCH;
      endcase
   end

   // State and output registers; reset wins over every state including
   // a pending EXEC and HALTED.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q       <= ST_FETCH;
         ir_q          <= 8'd0;
         pc_load_n_q   <= 1'b1;
         pc_hold_q     <= 1'b1;
         pc_target_q   <= 4'd0;
         exec_strobe_q <= 1'b0;
         halted_q      <= 1'b0;
         stack_err_q   <= 1'b0;
         wrap_event_q  <= 1'b0;
         sp_q          <= '0;
      end else begin
         state_q       <= state_d;
         ir_q          <= ir_d;
         pc_load_n_q   <= pc_load_n_d;
         pc_hold_q     <= pc_hold_d;
         pc_target_q   <= pc_target_d;
         exec_strobe_q <= exec_strobe_d;
         halted_q      <= halted_d;
         stack_err_q   <= stack_err_d;
         wrap_event_q  <= wrap_event_d;
         sp_q          <= sp_d;
      end
   end

   // Return-address storage has no reset; the pointer alone defines which
   // entries are meaningful.
   always_ff @(posedge clock) begin
      if (push_en) begin
         stack_q[wr_idx] <= push_data;
      end
   end

   assign pc_load_n   = pc_load_n_q;
   assign pc_hold     = pc_hold_q;
   assign pc_target   = pc_target_q;
   assign ir          = ir_q;
   assign exec_strobe = exec_strobe_q;
   assign halted      = halted_q;
   assign stack_err   = stack_err_q;
   assign wrap_event  = wrap_event_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer
// Bench for pc_sequencer. It models the external 4-bit loadable PC and a
// 16-word instruction memory. Directed programs push their hand-derived
// EXEC-cycle expectations into a queue; a monitor pops one entry on every
// exec_strobe and also checks the PC value seen in the following FETCH.
module tb_pc_sequencer;

   logic       clock;
   logic       reset;
   logic [3:0] pc_value;
   logic       pc_tc;
   logic [7:0] instr;
   logic       zero_flag;
   logic       pc_load_n;
   logic       pc_hold;
   logic [3:0] pc_target;
   logic [7:0] ir;
   logic       exec_strobe;
   logic       halted;
   logic       stack_err;
   logic       wrap_event;

   logic [7:0] imem [16];
   logic [3:0] pc_start;

   int n_checks;
   int n_fail;
   int done_count;

   typedef struct {
      logic       load_n;
      logic       hold;
      logic [3:0] target;
      logic       wrap;
      logic       err;
      logic [7:0] ir;
      logic [3:0] next_pc;
   } exp_t;

   exp_t sb [$];

   pc_sequencer #(.STACK_DEPTH(4)) dut (
      .clock       (clock),
      .reset       (reset),
      .pc_value    (pc_value),
      .pc_tc       (pc_tc),
      .instr       (instr),
      .zero_flag   (zero_flag),
      .pc_load_n   (pc_load_n),
      .pc_hold     (pc_hold),
      .pc_target   (pc_target),
      .ir          (ir),
      .exec_strobe (exec_strobe),
      .halted      (halted),
      .stack_err   (stack_err),
      .wrap_event  (wrap_event)
   );

   // Free-running clock.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // External program counter: parked at pc_start while reset is low,
   // otherwise obeys the sequencer's load/hold pins.
   always_ff @(posedge clock) begin
      if (!reset) pc_value <= pc_start;
      else if (!pc_load_n) pc_value <= pc_target;
      else if (!pc_hold) pc_value <= pc_value + 4'd1;
   end

   assign pc_tc = (pc_value == 4'd15);
   assign instr = imem[pc_value];

   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic pushInc(input logic [7:0] w, input logic [3:0] nxt,
                          input logic wr, input logic er);
      exp_t e;
      e.load_n = 1'b1; e.hold = 1'b0; e.target = 4'd0;
      e.wrap = wr; e.err = er; e.ir = w; e.next_pc = nxt;
      sb.push_back(e);
   endtask

   task automatic pushLoad(input logic [7:0] w, input logic [3:0] tgt,
                           input logic er);
      exp_t e;
      e.load_n = 1'b0; e.hold = 1'b1; e.target = tgt;
      e.wrap = 1'b0; e.err = er; e.ir = w; e.next_pc = tgt;
      sb.push_back(e);
   endtask

   // Hold reset low over two edges with the PC parked at start; clears
   // the program and confirms the previous program consumed its queue.
   task automatic doReset(input logic [3:0] start);
      reset = 1'b0;
      pc_start = start;
      zero_flag = 1'b0;
      for (int i = 0; i < 16; i++) imem[i] = 8'h00;
      repeat (2) @(posedge clock);
      @(negedge clock);
      #1;
      checkOutput("sb_empty", 32'(sb.size()), 32'd0);
      sb.delete();
   endtask

   task automatic checkReset();
      checkOutput("rst_pc_load_n", 32'(pc_load_n), 32'd1);
      checkOutput("rst_pc_hold", 32'(pc_hold), 32'd1);
      checkOutput("rst_pc_target", 32'(pc_target), 32'd0);
      checkOutput("rst_ir", 32'(ir), 32'd0);
      checkOutput("rst_exec_strobe", 32'(exec_strobe), 32'd0);
      checkOutput("rst_halted", 32'(halted), 32'd0);
      checkOutput("rst_stack_err", 32'(stack_err), 32'd0);
      checkOutput("rst_wrap_event", 32'(wrap_event), 32'd0);
   endtask

   // Release reset and wait, with a cycle budget, for n EXEC cycles.
   task automatic applyStimulus(input int n);
      int target;
      int limit;
      target = done_count + n;
      limit = 3 * n + 12;
      reset = 1'b1;
      for (int c = 0; c < limit && done_count < target; c++) begin
         @(negedge clock);
         #1;
      end
      checkOutput("exec_count", 32'(done_count >= target), 32'd1);
   endtask

   // Monitor: one scoreboard entry per EXEC cycle, then the PC it produced.
   initial begin
      exp_t e;
      done_count = 0;
      forever begin
         @(negedge clock);
         if (exec_strobe === 1'b1) begin
            if (sb.size() == 0) begin
               checkOutput("unexpected_exec", 32'(sb.size()), 32'd1);
            end else begin
               e = sb.pop_front();
               checkOutput("pc_load_n", 32'(pc_load_n), 32'(e.load_n));
               if (e.load_n == 1'b0)
                  checkOutput("pc_target", 32'(pc_target), 32'(e.target));
               else
                  checkOutput("pc_hold", 32'(pc_hold), 32'(e.hold));
               checkOutput("wrap_event", 32'(wrap_event), 32'(e.wrap));
               checkOutput("stack_err", 32'(stack_err), 32'(e.err));
               checkOutput("ir", 32'(ir), 32'(e.ir));
               @(negedge clock);
               checkOutput("next_pc", 32'(pc_value), 32'(e.next_pc));
               done_count++;
            end
         end
      end
   end

   // Bound the whole run.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [3:0] p;
      n_checks = 0;
      n_fail = 0;
      reset = 1'b0;
      zero_flag = 1'b0;
      pc_start = 4'd0;
      for (int i = 0; i < 16; i++) imem[i] = 8'h00;

      // Reset state.
      doReset(4'd0);
      checkReset();

      // NOPs (and two unassigned opcodes) across all 16 addresses, wrap once.
      doReset(4'd0);
      imem[5] = 8'h7F;
      imem[9] = 8'hF3;
      for (int i = 0; i < 17; i++) begin
         p = 4'(i);
         pushInc(imem[p], p + 4'd1, p == 4'd15, 1'b0);
      end
      applyStimulus(17);

      // JMP 0xA at PC 2.
      doReset(4'd2);
      imem[2] = 8'h1A;
      pushLoad(8'h1A, 4'hA, 1'b0);
      pushInc(8'h00, 4'hB, 1'b0, 1'b0);
      applyStimulus(2);

      // JZ 5 at PC 3, taken and not taken.
      doReset(4'd3);
      imem[3] = 8'h25;
      zero_flag = 1'b1;
      pushLoad(8'h25, 4'h5, 1'b0);
      pushInc(8'h00, 4'h6, 1'b0, 1'b0);
      applyStimulus(2);
      doReset(4'd3);
      imem[3] = 8'h25;
      pushInc(8'h25, 4'h4, 1'b0, 1'b0);
      applyStimulus(1);

      // JNZ 5 at PC 3, mirror image.
      doReset(4'd3);
      imem[3] = 8'h35;
      pushLoad(8'h35, 4'h5, 1'b0);
      applyStimulus(1);
      doReset(4'd3);
      imem[3] = 8'h35;
      zero_flag = 1'b1;
      pushInc(8'h35, 4'h4, 1'b0, 1'b0);
      applyStimulus(1);

      // CALL 8 at PC 1, RET at 8 returns to 2.
      doReset(4'd1);
      imem[1] = 8'h48;
      imem[8] = 8'h50;
      pushLoad(8'h48, 4'h8, 1'b0);
      pushLoad(8'h50, 4'h2, 1'b0);
      pushInc(8'h00, 4'h3, 1'b0, 1'b0);
      applyStimulus(3);

      // Five nested CALLs overflow a 4-deep stack; RET pops the 4th push.
      doReset(4'd0);
      imem[0] = 8'h41;
      imem[1] = 8'h42;
      imem[2] = 8'h43;
      imem[3] = 8'h44;
      imem[4] = 8'h45;
      imem[5] = 8'h50;
      pushLoad(8'h41, 4'h1, 1'b0);
      pushLoad(8'h42, 4'h2, 1'b0);
      pushLoad(8'h43, 4'h3, 1'b0);
      pushLoad(8'h44, 4'h4, 1'b0);
      pushLoad(8'h45, 4'h5, 1'b1);
      pushLoad(8'h50, 4'h4, 1'b1);
      applyStimulus(6);

      // CALL at PC 15 pushes 0 and raises no wrap.
      doReset(4'd15);
      imem[15] = 8'h43;
      imem[3]  = 8'h50;
      pushLoad(8'h43, 4'h3, 1'b0);
      pushLoad(8'h50, 4'h0, 1'b0);
      pushInc(8'h00, 4'h1, 1'b0, 1'b0);
      applyStimulus(3);

      // RET on an empty stack at PC 6 increments and sets a sticky error.
      doReset(4'd6);
      imem[6] = 8'h50;
      pushInc(8'h50, 4'h7, 1'b0, 1'b1);
      pushInc(8'h00, 4'h8, 1'b0, 1'b1);
      applyStimulus(2);

      // Empty RET at PC 15 still wraps.
      doReset(4'd15);
      imem[15] = 8'h50;
      pushInc(8'h50, 4'h0, 1'b1, 1'b1);
      applyStimulus(1);

      // HALT at PC 4 after an error and a jump, then reset recovery.
      doReset(4'd0);
      imem[0] = 8'h50;
      imem[1] = 8'h13;
      imem[4] = 8'h60;
      pushInc(8'h50, 4'h1, 1'b0, 1'b1);
      pushLoad(8'h13, 4'h3, 1'b1);
      pushInc(8'h00, 4'h4, 1'b0, 1'b1);
      applyStimulus(3);
      for (int c = 0; c < 10 && halted !== 1'b1; c++) begin
         @(negedge clock);
         #1;
      end
      checkOutput("halted", 32'(halted), 32'd1);
      checkOutput("halt_ir", 32'(ir), 32'h60);
      for (int c = 0; c < 24; c++) begin
         @(negedge clock);
         checkOutput("halt_pc", 32'(pc_value), 32'd4);
         checkOutput("halt_ctrl", 32'({exec_strobe, pc_hold, pc_load_n, halted}), 32'b0111);
      end
      reset = 1'b0;
      @(posedge clock);
      @(negedge clock);
      checkReset();

      // After reset the sequencer starts again from FETCH.
      doReset(4'd0);
      pushInc(8'h00, 4'h1, 1'b0, 1'b0);
      applyStimulus(1);
      doReset(4'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Fetch/branch sequencer that drives the control pins of the 4-bit loadable program counter and consumes its count value and terminal-count flag.
- Each instruction takes a fixed 3-cycle FETCH/DECODE/EXEC cycle.
- Decides per instruction whether the PC holds, increments or loads a target.
- Keeps a small return-address stack for CALL/RET.

Parameters:
- STACK_DEPTH, 4, number of return-address entries (2..8).

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low; clock clock.
- pc_value  input  4  current PC count value.
- pc_tc  input  1  PC terminal count (1 when PC == 15).
- instr  input  8  instruction word at pc_value; [7:4] opcode, [3:0] address operand.
- zero_flag  input  1  ALU zero flag.
- pc_load_n  output  1  active-low parallel load to PC.
- pc_hold  output  1  1 = PC holds; 0 = PC increments (only when pc_load_n = 1).
- pc_target  output  4  parallel load value to PC.
- ir  output  8  latched instruction register.
- exec_strobe  output  1  1 during the EXEC cycle.
- halted  output  1  1 once HALT has executed.
- stack_err  output  1  sticky overflow/underflow flag.
- wrap_event  output  1  one-cycle pulse when a sequential increment wraps 15 -> 0.

Behaviour:
- Reset (reset == 0 at a rising edge):
  - state = FETCH, pc_load_n = 1, pc_hold = 1, pc_target = 0, ir = 0.
  - exec_strobe = 0, halted = 0, stack_err = 0, wrap_event = 0.
  - Stack pointer = 0; stack contents are don't-care.
  - Reset overrides every other event, including mid-EXEC and HALTED.
- All outputs are registered. Outside EXEC: pc_load_n = 1 and pc_hold = 1, so the PC is frozen.
- FETCH (1 cycle): ir <= instr; next state DECODE.
- DECODE (1 cycle):
  - Evaluate ir and sample zero_flag, pc_value and pc_tc.
  - Register the EXEC control values.
  - Next state is EXEC, or HALTED for opcode 6.
- EXEC (1 cycle): exec_strobe = 1 and the controls are applied. The PC changes on the rising edge that ends EXEC. Next state FETCH.
- Opcode actions in EXEC:
  - 0 NOP, and 7..15 (unassigned): increment (pc_hold = 0, pc_load_n = 1).
  - 1 JMP a: pc_load_n = 0, pc_target = a.
  - 2 JZ a: load a if zero_flag was 1 in DECODE, else increment.
  - 3 JNZ a: load a if zero_flag was 0 in DECODE, else increment.
  - 4 CALL a:
    - Push (pc_value + 1) mod 16, then load a.
    - If the stack is already full (STACK_DEPTH entries): no push, stack_err <= 1, load a anyway.
  - 5 RET:
    - Pop and load the popped value.
    - If the stack is empty: stack_err <= 1 and increment instead.
  - 6 HALT: go to HALTED.
- HALTED:
  - halted = 1, pc_hold = 1, pc_load_n = 1, exec_strobe = 0.
  - Stays there until reset.
  - ir keeps the HALT word.
- Wrap:
  - If EXEC increments and pc_tc was 1 in DECODE, wrap_event = 1 during that EXEC cycle, otherwise 0.
  - Loads never raise wrap_event.
  - A CALL at PC 15 pushes 0.
- Stack: LIFO. Push and pop never occur in the same cycle. stack_err is cleared only by reset.
- Throughput: 1 instruction per 3 cycles. pc_value is stable through FETCH and DECODE.

Test Plan:
1. Reset, then NOP at all 16 addresses:
   - PC steps 0 -> 1 -> ... -> 15 -> 0, one step every 3 cycles.
   - wrap_event pulses exactly once, in the EXEC that leaves 15.
2. JMP 0xA at PC 2 -> pc_load_n = 0 with pc_target = 0xA during EXEC; next FETCH sees pc_value = 10.
3. JZ 0x5 at PC 3:
   - With zero_flag = 1 -> PC becomes 5.
   - Repeat with zero_flag = 0 -> PC becomes 4.
   - JNZ gives the mirror-image results.
4. CALL 0x8 at PC 1, then RET at 8 -> PC goes 1 -> 8 -> 2, stack_err stays 0. Then 5 nested CALLs with STACK_DEPTH = 4 -> stack_err = 1 after the 5th, and the jump is still taken.
5. RET with an empty stack at PC 6 -> PC becomes 7 and stack_err = 1.
6. HALT at PC 4 -> halted = 1 and the PC frozen for 20+ cycles. Then reset low for one edge -> every output returns to its reset value, state FETCH.
